// File: rtl/mem_read_arb.sv
// Two-requester AXI read-burst arbiter and cache-line refill sequencer (fetch vs. data stage).
// Define CRITICAL_WORD_FIRST_EN for WRAP bursts that start at the missing word.
module mem_read_arb #(
    parameter int unsigned B = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        if_req,
    input  logic [63:0]                 if_addr,
    output logic                        if_done,
    input  logic                        d_req,
    input  logic [63:0]                 d_addr,
    output logic                        d_done,
    output logic                        fill_valid,
    output logic                        fill_sel,
    output logic [$clog2(B/8)-1:0]      fill_idx,
    output logic [63:0]                 fill_data,
    output logic                        fill_last,
    output logic                        fill_err,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [63:0]                 m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic [63:0]                 m_axi_rdata,
    input  logic                        m_axi_rlast,
    input  logic [1:0]                  m_axi_rresp
);

    localparam int unsigned BEATS = B / 8;
    localparam int unsigned BW    = $clog2(BEATS);
    localparam int unsigned CW    = BW + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            sel_q, sel_d;
    logic [BW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            arvalid_d, rready_d;
    logic [63:0]     araddr_d;
    logic [7:0]      arlen_d;
    logic [2:0]      arsize_d;
    logic [1:0]      arburst_d;
    logic            fill_valid_d, fill_sel_d, fill_last_d, fill_err_d;
    logic [BW-1:0]   fill_idx_d;
    logic [63:0]     fill_data_d;
    logic            if_done_d, d_done_d;

    logic            grant_data;
    logic [63:0]     req_addr;
    logic [63:0]     start_addr;
    logic [BW-1:0]   start_idx;
    logic [CW-1:0]   beat_no;

    // On a tie the requester not named by last_grant wins.
    assign grant_data = d_req && !(if_req && last_grant_q);
    assign req_addr   = grant_data ? d_addr : if_addr;
    assign beat_no    = cnt_q + CW'(1);

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [1:0] BURST = 2'd2;
    assign start_addr = req_addr & ~64'd7;
    assign start_idx  = req_addr[BW+2:3];
`else
    localparam logic [1:0] BURST = 2'd1;
    assign start_addr = req_addr & ~64'(B - 1);
    assign start_idx  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b0;
            sel_q         <= 1'b0;
            idx_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
            fill_valid    <= 1'b0;
            fill_sel      <= 1'b0;
            fill_idx      <= '0;
            fill_data     <= '0;
            fill_last     <= 1'b0;
            fill_err      <= 1'b0;
            if_done       <= 1'b0;
            d_done        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            sel_q         <= sel_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arlen   <= arlen_d;
            m_axi_arsize  <= arsize_d;
            m_axi_arburst <= arburst_d;
            fill_valid    <= fill_valid_d;
            fill_sel      <= fill_sel_d;
            fill_idx      <= fill_idx_d;
            fill_data     <= fill_data_d;
            fill_last     <= fill_last_d;
            fill_err      <= fill_err_d;
            if_done       <= if_done_d;
            d_done        <= d_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        araddr_d     = m_axi_araddr;
        arlen_d      = m_axi_arlen;
        arsize_d     = m_axi_arsize;
        arburst_d    = m_axi_arburst;
        fill_valid_d = 1'b0;
        fill_sel_d   = fill_sel;
        fill_idx_d   = '0;
        fill_data_d  = '0;
        fill_last_d  = 1'b0;
        fill_err_d   = 1'b0;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    sel_d        = grant_data;
                    last_grant_d = grant_data;
                    araddr_d     = start_addr;
                    arlen_d      = 8'(BEATS - 1);
                    arsize_d     = 3'd3;
                    arburst_d    = BURST;
                    idx_d        = start_idx;
                    cnt_d        = '0;
                    err_d        = 1'b0;
                    arvalid_d    = 1'b1;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    rready_d = 1'b1;
                    state_d  = DATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            DATA: begin
                rready_d = 1'b1;
                if (m_axi_rvalid && m_axi_rready) begin
                    fill_valid_d = 1'b1;
                    fill_sel_d   = sel_q;
                    fill_idx_d   = idx_q;
                    fill_data_d  = m_axi_rdata;
                    fill_last_d  = m_axi_rlast;
                    idx_d        = idx_q + BW'(1);
                    cnt_d        = beat_no;
                    err_d        = err_q || (m_axi_rresp != 2'd0);
                    if (m_axi_rlast) begin
                        // Short burst is an error; final beat and done share a cycle.
                        err_d      = err_d || (beat_no != CW'(BEATS));
                        fill_err_d = err_d;
                        if_done_d  = !sel_q;
                        d_done_d   = sel_q;
                        rready_d   = 1'b0;
                        state_d    = DONE;
                    end else if (beat_no >= CW'(BEATS)) begin
                        err_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_read_arb.sv
// Scoreboard bench for mem_read_arb: directed transactions, queued expectations, negedge monitor.
module tb_mem_read_arb;

    localparam int unsigned BEATS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0;
    logic [63:0] if_addr = '0, d_addr = '0;
    logic        if_done, d_done;
    logic        fill_valid, fill_sel, fill_last, fill_err;
    logic [2:0]  fill_idx;
    logic [63:0] fill_data;
    logic        m_axi_arvalid, m_axi_rready;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;

    typedef struct {
        logic        sel;
        logic [2:0]  idx;
        logic [63:0] data;
        logic        last;
        logic        err;
    } fill_exp_t;

    fill_exp_t   fill_q[$];
    logic [63:0] ar_q[$];
    int          errors = 0;
    int          checks = 0;

    mem_read_arb #(.B(64)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .d_req(d_req), .d_addr(d_addr), .d_done(d_done),
        .fill_valid(fill_valid), .fill_sel(fill_sel), .fill_idx(fill_idx),
        .fill_data(fill_data), .fill_last(fill_last), .fill_err(fill_err),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp)
    );

    always #5 clk = ~clk;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic [1:0] EXP_BURST = 2'd2;
    function automatic logic [63:0] exp_araddr(input logic [63:0] a);
        return {a[63:3], 3'b000};
    endfunction
    function automatic logic [2:0] exp_start(input logic [63:0] a);
        return a[5:3];
    endfunction
`else
    localparam logic [1:0] EXP_BURST = 2'd1;
    function automatic logic [63:0] exp_araddr(input logic [63:0] a);
        return {a[63:6], 6'b000000};
    endfunction
    function automatic logic [2:0] exp_start(input logic [63:0] a);
        return (a == 64'd0) ? 3'd0 : 3'd0;
    endfunction
`endif

    function automatic logic [63:0] beat_data(input logic [63:0] a, input int i);
        return {a[31:0], 24'hBEEF00, 8'(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        fill_exp_t e;
        logic [63:0] a;
        forever begin
            @(negedge clk);
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_q.size() == 0) begin
                    check("unexpected_ar", 64'(m_axi_arvalid), 64'd0);
                end else begin
                    a = ar_q.pop_front();
                    check("araddr", m_axi_araddr, a);
                    check("arlen", 64'(m_axi_arlen), 64'd7);
                    check("arsize", 64'(m_axi_arsize), 64'd3);
                    check("arburst", 64'(m_axi_arburst), 64'(EXP_BURST));
                end
            end
            if (fill_valid) begin
                if (fill_q.size() == 0) begin
                    check("unexpected_fill", 64'(fill_valid), 64'd0);
                end else begin
                    e = fill_q.pop_front();
                    check("fill_sel", 64'(fill_sel), 64'(e.sel));
                    check("fill_idx", 64'(fill_idx), 64'(e.idx));
                    check("fill_data", fill_data, e.data);
                    check("fill_last", 64'(fill_last), 64'(e.last));
                    check("if_done", 64'(if_done), 64'(e.last && !e.sel));
                    check("d_done", 64'(d_done), 64'(e.last && e.sel));
                    if (e.last) check("fill_err", 64'(fill_err), 64'(e.err));
                end
            end else begin
                check("stray_done", 64'({if_done, d_done}), 64'd0);
            end
        end
    endtask

    // AXI slave model for one burst; drops the winner's request in the done cycle.
    task automatic serve(input logic sel, input logic [63:0] addr, input int nbeats,
                         input int err_beat, input int ar_wait, input int exp_lat);
        int          lat;
        logic        e;
        logic [63:0] a0;
        logic [2:0]  st;
        fill_exp_t   x;
        e  = (err_beat >= 0) || (nbeats != BEATS);
        st = exp_start(addr);
        ar_q.push_back(exp_araddr(addr));
        lat = 0;
        while (!m_axi_arvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!m_axi_arvalid) begin
            check("arvalid_timeout", 64'(m_axi_arvalid), 64'd1);
            return;
        end
        if (exp_lat >= 0) check("ar_latency", 64'(lat), 64'(exp_lat));
        a0 = m_axi_araddr;
        for (int k = 0; k < ar_wait; k++) begin
            check("arvalid_hold", 64'(m_axi_arvalid), 64'd1);
            check("araddr_stable", m_axi_araddr, a0);
            check("no_early_fill", 64'(fill_valid), 64'd0);
            @(posedge clk); #1;
        end
        m_axi_arready = 1'b1;
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        check("rready", 64'(m_axi_rready), 64'd1);
        for (int i = 0; i < nbeats; i++) begin
            x.sel  = sel;
            x.idx  = st + 3'(i);
            x.data = beat_data(addr, i);
            x.last = (i == nbeats - 1);
            x.err  = e;
            fill_q.push_back(x);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = x.data;
            m_axi_rlast  = x.last;
            m_axi_rresp  = (i == err_beat) ? 2'd2 : 2'd0;
            @(posedge clk); #1;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'd0;
        if (sel) d_req = 1'b0;
        else     if_req = 1'b0;
    endtask

    initial begin
        fill_exp_t x;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
                $fatal(1);
            end
        join_none

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_fill_valid", 64'(fill_valid), 64'd0);
        check("rst_fill_sel", 64'(fill_sel), 64'd0);
        check("rst_done", 64'({if_done, d_done}), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);

        // Fetch-only miss at 0x1028.
        @(posedge clk); #1;
        if_addr = 64'h1028; if_req = 1'b1;
        serve(1'b0, 64'h1028, 8, -1, 0, 1);

        // Tie right after reset: data first, then fetch after one bubble.
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        if_addr = 64'h2000; d_addr = 64'h3040;
        if_req = 1'b1; d_req = 1'b1;
        serve(1'b1, 64'h3040, 8, -1, 0, 1);
        serve(1'b0, 64'h2000, 8, -1, 0, 2);

        // Data-only, then a tie that must go to fetch.
        @(posedge clk); #1;
        d_addr = 64'h4080; d_req = 1'b1;
        serve(1'b1, 64'h4080, 8, -1, 0, 1);
        @(posedge clk); #1;
        if_addr = 64'h5100; d_addr = 64'h6180;
        if_req = 1'b1; d_req = 1'b1;
        serve(1'b0, 64'h5100, 8, -1, 0, 1);
        serve(1'b1, 64'h6180, 8, -1, 0, 2);

        // arready held low for 5 cycles.
        @(posedge clk); #1;
        if_addr = 64'h7218; if_req = 1'b1;
        serve(1'b0, 64'h7218, 8, -1, 5, 1);

        // rresp error on beat 3, then a clean transaction.
        @(posedge clk); #1;
        d_addr = 64'h8000; d_req = 1'b1;
        serve(1'b1, 64'h8000, 8, 3, 0, 1);
        @(posedge clk); #1;
        if_addr = 64'h9040; if_req = 1'b1;
        serve(1'b0, 64'h9040, 8, -1, 0, 1);

        // Early rlast on beat 6 of 8.
        @(posedge clk); #1;
        d_addr = 64'hA000; d_req = 1'b1;
        serve(1'b1, 64'hA000, 6, -1, 0, 1);

        // Reset during the 3rd beat.
        @(posedge clk); #1;
        if_addr = 64'hB000; if_req = 1'b1;
        ar_q.push_back(exp_araddr(64'hB000));
        @(posedge clk); #1;
        check("rst_test_arvalid", 64'(m_axi_arvalid), 64'd1);
        m_axi_arready = 1'b1;
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            x.sel = 1'b0; x.idx = exp_start(64'hB000) + 3'(i);
            x.data = beat_data(64'hB000, i); x.last = 1'b0; x.err = 1'b0;
            fill_q.push_back(x);
            m_axi_rvalid = 1'b1; m_axi_rdata = x.data;
            @(posedge clk); #1;
        end
        reset = 1'b1;
        if_req = 1'b0;
        m_axi_rdata = beat_data(64'hB000, 2);
        @(posedge clk); #1;
        reset = 1'b0;
        m_axi_rvalid = 1'b0;
        check("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("midrst_rready", 64'(m_axi_rready), 64'd0);
        check("midrst_fill_valid", 64'(fill_valid), 64'd0);
        check("midrst_fill_data", fill_data, 64'd0);
        check("midrst_done", 64'({if_done, d_done}), 64'd0);
        d_addr = 64'hC0C0; d_req = 1'b1;
        serve(1'b1, 64'hC0C0, 8, -1, 0, 1);

        repeat (4) @(posedge clk);
        #1;
        check("fill_q_empty", 64'(fill_q.size()), 64'd0);
        check("ar_q_empty", 64'(ar_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
